dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data RAM between the CPU pipeline's MEM-stage load/store port (port 0) and a debug/program-loader port (port 1). It grants at most one access per cycle, routes the one-cycle-latency read data back to the owning requester, and generates the pipeline stall. CPU has fixed priority; a starvation counter and a lock mode guarantee debug progress. Sits between `processor` and `dmem` inside `cpu`.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width; fixed at 32, giving 4 byte strobes.
- `STARVE_LIMIT`, 4: consecutive denied debug-request cycles before debug is force-granted; range 1..15.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `m0_req`, `m1_req`  in  1  access request, held until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address, passed through unmodified.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte write enables.
- `m1_lock`  in  1  debug requests exclusive ownership of the memory.
- `m0_gnt`, `m1_gnt`  out  1  combinational accept this cycle; the request is consumed at the clock edge.
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid; one-cycle pulse per granted read.
- `m0_rdata`, `m1_rdata`  out  32  read data, qualified by the matching `rvalid`.
- `o_cpu_stall`  out  1  equals `m0_req & ~m0_gnt`.
- `o_dbg_locked`  out  1  high while in the LOCK state.
- `mem_en`, `mem_we`  out  1  RAM enable and write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  32  RAM write data.
- `mem_wstrb`  out  4  RAM byte strobes.
- `mem_rdata`  in  32  RAM read data, valid the cycle after a read enable.

## Operation
- **FSM states:**
  - ARB: normal arbitration.
  - LOCK: debug owns the RAM exclusively.
  - DRAIN: one cycle to retire an in-flight CPU read before entering LOCK.
- **ARB grant rule, in priority order:**
  1. If `starve_cnt == STARVE_LIMIT` and `m1_req`, grant port 1.
  2. Else if `m0_req`, grant port 0.
  3. Else if `m1_req`, grant port 1.
  - Otherwise no grant.
- **starve_cnt:**
  - Increments (saturating at STARVE_LIMIT) when `m1_req` is high and `m1_gnt` is low.
  - Clears when port 1 is granted or `m1_req` is low.
- **Entering LOCK:**
  - From ARB, when `m1_lock` is high: go to DRAIN if a port-0 read was granted in that same cycle, else go to LOCK. `m0_gnt` is still legal in that transition cycle.
  - DRAIN always proceeds to LOCK on the next cycle.
  - In DRAIN and LOCK, `m0_gnt` = 0. In LOCK, `m1_gnt = m1_req`.
- **Leaving LOCK:** LOCK returns to ARB the cycle after `m1_lock` falls. `starve_cnt` is cleared on exit.
- **Memory mux:**
  - `mem_en` = grant to either port.
  - `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` are taken from the granted port. When nothing is granted they are all zero.
- **Response tracking:**
  - Registered `rd_pend` (1 bit) and `rd_owner` (1 bit) are set on a granted read.
  - In the next cycle, the owner's `rvalid` = 1 and its `rdata` = `mem_rdata`.
  - The non-owner's `rdata` is 0.
  - Writes produce no `rvalid`.
  - A write with `wstrb` = 0 is still granted and passed through to the RAM.
- Back-to-back reads from either port, or alternating between ports, sustain one grant per cycle.

## Timing
- **Grant:** combinational from `req` and registered state, zero cycles after the request.
- **Read latency:** `rvalid` is asserted exactly 1 cycle after the granted cycle.
- **Reset:**
  - `i_rst` high clears immediately and asynchronously: FSM to ARB; `starve_cnt`, `rd_pend`, `rd_owner` to 0.
  - All `gnt`, `rvalid`, `rdata`, `mem_*`, `o_cpu_stall` and `o_dbg_locked` are forced to 0 while reset is high.
  - A pending read response at reset is dropped, never delivered.
- **Worst-case debug wait in ARB:** STARVE_LIMIT cycles before the forced grant.
- **Worst-case LOCK entry:** 2 cycles when DRAIN is needed, otherwise 1.
- **`m1_lock` rising while the force-grant condition is true:** the force-grant happens first, in the same cycle, then the FSM enters LOCK.

## Test plan
- **Reset:** assert `i_rst` mid-read (port 0 read granted at addr 0x8) -> no `m0_rvalid` is ever seen; all outputs are 0 during reset; FSM is ARB after release.
- **CPU read after write:** port-0 write 0x0000000D to addr 8 with wstrb 0xF, then read addr 8 -> `m0_rvalid` 1 cycle after the read grant with `m0_rdata` = 0x0000000D; `o_cpu_stall` = 0 throughout.
- **Contention:** both ports request every cycle with STARVE_LIMIT = 4 -> port 1 is granted exactly once every 5 cycles; `o_cpu_stall` is high only on those cycles; `m1_rdata` returns 0x1E preloaded at addr 28.
- **Simultaneous single requests:** `m0_req` and `m1_req` in the same cycle with `starve_cnt` = 0 -> `m0_gnt` = 1 and `m1_gnt` = 0; port 1 is granted the next cycle once `m0_req` drops.
- **Lock with drain:** `m1_lock` rises in the same cycle as a port-0 read grant -> DRAIN for 1 cycle, `m0_rvalid` is delivered, then LOCK; three debug writes of 12, 30, 13 to addrs 0, 4, 8 complete in 3 consecutive cycles; `o_cpu_stall` stays high.
- **Lock release:** `m1_lock` falls -> FSM is in ARB the next cycle; `starve_cnt` = 0; a pending `m0_req` is granted that cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM-stage
// port (port 0) and the debug/program-loader port (port 1).
// The CPU has fixed priority. A starvation counter force-grants a waiting
// debug request, and a lock mode gives the debug port exclusive ownership.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,

  output logic                  o_cpu_stall,
  output logic                  o_dbg_locked,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;

  logic       gnt0, gnt1;
  logic       force_dbg;
  logic       rd0, rd1;

  assign force_dbg = (starve_cnt_q == LIMIT) && m1_req;
  assign rd0       = gnt0 & ~m0_we;
  assign rd1       = gnt1 & ~m1_we;

  // Grant decision: combinational from requests and registered state.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      unique case (state_q)
        ST_ARB: begin
          if (force_dbg)   gnt1 = 1'b1;
          else if (m0_req) gnt0 = 1'b1;
          else if (m1_req) gnt1 = 1'b1;
        end
        ST_LOCK:  gnt1 = m1_req;
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  // Next-state logic for the FSM, starvation counter and read tracking.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    rd_pend_d    = rd0 | rd1;
    rd_owner_d   = rd_owner_q;

    unique case (state_q)
      ST_ARB: begin
        // A CPU read granted on the lock request cycle must retire first.
        if (m1_lock) state_d = rd0 ? ST_DRAIN : ST_LOCK;
      end
      ST_DRAIN: state_d = ST_LOCK;
      ST_LOCK: begin
        if (!m1_lock) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase

    if (m1_req && !gnt1) begin
      if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = '0;
    end
    if (state_q == ST_LOCK && !m1_lock) starve_cnt_d = '0;

    if (rd0)      rd_owner_d = 1'b0;
    else if (rd1) rd_owner_d = 1'b1;
  end

  // State registers with asynchronous reset; a pending read is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_ARB;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // RAM request mux: taken from the granted port, all zero when idle.
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_wstrb = m0_wstrb;
    end else if (gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wstrb = m1_wstrb;
    end
  end

  // Read response routing to the owner; the other port sees zero data.
  always_comb begin
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (!i_rst && rd_pend_q) begin
      if (rd_owner_q) begin
        m1_rvalid = 1'b1;
        m1_rdata  = mem_rdata;
      end else begin
        m0_rvalid = 1'b1;
        m0_rdata  = mem_rdata;
      end
    end
  end

  assign m0_gnt       = gnt0;
  assign m1_gnt       = gnt1;
  assign o_cpu_stall  = m0_req & ~gnt0 & ~i_rst;
  assign o_dbg_locked = (state_q == ST_LOCK) & ~i_rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed stimulus with a read-response
// scoreboard and a small behavioural RAM attached to the mem_* port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        o_cpu_stall, o_dbg_locked;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .o_cpu_stall(o_cpu_stall), .o_dbg_locked(o_dbg_locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port RAM, one-cycle read latency; addr 28 holds 0x1E.
  logic [31:0] ram [0:15];
  bit          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] = '0;
      ram[7] = 32'h1E;
      ram_init = 1'b1;
    end
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram[mem_addr[5:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[5:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rd(input bit port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic drv0(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = strb;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wstrb = strb;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, '0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Monitor: every rvalid pops the oldest expected response.
  exp_t mon_e;
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexpected: got m0_rvalid=%0d m1_rvalid=%0d want none", m0_rvalid, m1_rvalid);
      end else begin
        mon_e = sbq.pop_front();
        check("rv_port", {31'b0, m1_rvalid}, {31'b0, mon_e.port});
        check("rv_both", {31'b0, m0_rvalid & m1_rvalid}, 32'h0);
        check("rv_data", mon_e.port ? m1_rdata : m0_rdata, mon_e.data);
        check("rv_other_rdata", mon_e.port ? m0_rdata : m1_rdata, 32'h0);
        check("rv_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    m1_lock = 1'b0;

    // Reset with every request active: all outputs held at zero.
    #1 rst = 1'b1;
    drv0(1'b1, 1'b0, 32'h8, 32'hA5A5A5A5, 4'hF);
    drv1(1'b1, 1'b1, 32'h4, 32'h5A5A5A5A, 4'hF);
    m1_lock = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    check("rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_stall", {31'b0, o_cpu_stall}, 32'h0);
    check("rst_locked", {31'b0, o_dbg_locked}, 32'h0);
    @(negedge clk);
    idle();
    m1_lock = 1'b0;
    rst = 1'b0;

    // CPU write then read back, plus a zero-strobe write passed through.
    @(negedge clk);
    drv0(1'b1, 1'b1, 32'h8, 32'h0000000D, 4'hF);
    #1;
    check("wr_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    check("wr_stall", {31'b0, o_cpu_stall}, 32'h0);
    check("wr_mem_we", {31'b0, mem_we}, 32'h1);
    check("wr_mem_addr", mem_addr, 32'h8);
    check("wr_mem_wdata", mem_wdata, 32'hD);
    check("wr_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
    @(negedge clk);
    drv0(1'b1, 1'b1, 32'h8, 32'h000000FF, 4'h0);
    #1;
    check("wr0_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    check("wr0_mem_en", {31'b0, mem_en}, 32'h1);
    check("wr0_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    @(negedge clk);
    drv0(1'b1, 1'b0, 32'h8, '0, '0);
    #1;
    check("rd_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    check("rd_stall", {31'b0, o_cpu_stall}, 32'h0);
    check("rd_mem_we", {31'b0, mem_we}, 32'h0);
    expect_rd(1'b0, 32'h0000000D);
    @(negedge clk);
    idle();

    // Reset asserted while a port-0 read is in flight: response is dropped.
    @(negedge clk);
    drv0(1'b1, 1'b0, 32'h8, '0, '0);
    #1;
    check("rstrd_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstrd_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
    check("rstrd_m0_rdata", m0_rdata, 32'h0);
    check("rstrd_mem_en", {31'b0, mem_en}, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    check("rstrd_locked", {31'b0, o_dbg_locked}, 32'h0);

    // Simultaneous single requests: CPU first, debug next cycle.
    @(negedge clk);
    drv0(1'b1, 1'b0, 32'h8, '0, '0);
    drv1(1'b1, 1'b0, 32'd28, '0, '0);
    #1;
    check("sim_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    check("sim_m1_gnt", {31'b0, m1_gnt}, 32'h0);
    expect_rd(1'b0, 32'hD);
    @(negedge clk);
    drv0(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("sim_next_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    check("sim_next_mem_addr", mem_addr, 32'd28);
    expect_rd(1'b1, 32'h1E);
    @(negedge clk);
    idle();

    // Contention: debug is force-granted once every 5 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drv0(1'b1, 1'b0, 32'h8, '0, '0);
      drv1(1'b1, 1'b0, 32'd28, '0, '0);
      #1;
      check("cont_m1_gnt", {31'b0, m1_gnt}, (i % 5 == 4) ? 32'h1 : 32'h0);
      check("cont_m0_gnt", {31'b0, m0_gnt}, (i % 5 == 4) ? 32'h0 : 32'h1);
      check("cont_stall", {31'b0, o_cpu_stall}, (i % 5 == 4) ? 32'h1 : 32'h0);
      if (i % 5 == 4) expect_rd(1'b1, 32'h1E);
      else            expect_rd(1'b0, 32'hD);
    end
    @(negedge clk);
    idle();

    // Lock requested on the cycle of a CPU read grant: DRAIN, then LOCK.
    @(negedge clk);
    drv0(1'b1, 1'b0, 32'h8, '0, '0);
    m1_lock = 1'b1;
    #1;
    check("lk_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    check("lk_locked0", {31'b0, o_dbg_locked}, 32'h0);
    expect_rd(1'b0, 32'hD);
    @(negedge clk);
    #1;
    check("drain_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    check("drain_stall", {31'b0, o_cpu_stall}, 32'h1);
    check("drain_locked", {31'b0, o_dbg_locked}, 32'h0);
    @(negedge clk);
    drv1(1'b1, 1'b1, 32'h0, 32'd12, 4'hF);
    #1;
    check("lock_locked", {31'b0, o_dbg_locked}, 32'h1);
    check("lock_w0_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    check("lock_w0_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    check("lock_w0_stall", {31'b0, o_cpu_stall}, 32'h1);
    check("lock_w0_mem_wdata", mem_wdata, 32'd12);
    @(negedge clk);
    drv1(1'b1, 1'b1, 32'h4, 32'd30, 4'hF);
    #1;
    check("lock_w1_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    check("lock_w1_mem_addr", mem_addr, 32'h4);
    check("lock_w1_stall", {31'b0, o_cpu_stall}, 32'h1);
    @(negedge clk);
    drv1(1'b1, 1'b1, 32'h8, 32'd13, 4'hF);
    #1;
    check("lock_w2_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    check("lock_w2_mem_wdata", mem_wdata, 32'd13);
    check("lock_w2_stall", {31'b0, o_cpu_stall}, 32'h1);
    @(negedge clk);
    drv1(1'b1, 1'b0, 32'h4, '0, '0);
    #1;
    check("lock_rd_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    expect_rd(1'b1, 32'd30);

    // Lock release: still locked this cycle, ARB and CPU granted the next.
    @(negedge clk);
    drv1(1'b0, 1'b0, '0, '0, '0);
    m1_lock = 1'b0;
    #1;
    check("rel_locked", {31'b0, o_dbg_locked}, 32'h1);
    check("rel_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    @(negedge clk);
    #1;
    check("arb_locked", {31'b0, o_dbg_locked}, 32'h0);
    check("arb_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    check("arb_stall", {31'b0, o_cpu_stall}, 32'h0);
    expect_rd(1'b0, 32'hD);

    // Starvation count restarts at 0; lock rising with the forced grant.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv0(1'b1, 1'b0, 32'h8, '0, '0);
      if (i == 4) begin
        drv1(1'b1, 1'b1, 32'd12, 32'h55, 4'hF);
        m1_lock = 1'b1;
      end else begin
        drv1(1'b1, 1'b0, 32'd28, '0, '0);
      end
      #1;
      check("fl_m1_gnt", {31'b0, m1_gnt}, (i == 4) ? 32'h1 : 32'h0);
      check("fl_m0_gnt", {31'b0, m0_gnt}, (i == 4) ? 32'h0 : 32'h1);
      if (i != 4) expect_rd(1'b0, 32'hD);
    end
    @(negedge clk);
    drv1(1'b0, 1'b0, '0, '0, '0);
    m1_lock = 1'b0;
    #1;
    check("fl_locked", {31'b0, o_dbg_locked}, 32'h1);
    check("fl_lock_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    @(negedge clk);
    #1;
    check("fl_exit_locked", {31'b0, o_dbg_locked}, 32'h0);
    check("fl_exit_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    expect_rd(1'b0, 32'hD);
    @(negedge clk);
    idle();

    repeat (3) @(negedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
